// File: rtl/golden_nonce_reporter_if.sv
// Byte-stream link from the golden nonce reporter to the host-link UART TX.
//   tx_data  : current frame byte (reporter -> UART)
//   tx_valid : tx_data valid, held until accepted (reporter -> UART)
//   tx_ready : UART can take a byte this cycle (UART -> reporter)
interface golden_nonce_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/golden_nonce_reporter.sv
// Golden nonce reporter: captures winning {flag, nonce} results from the hash
// checker into a small FIFO and sends each as a 5-byte frame
// (SYNC_BYTE, nonce[31:24], [23:16], [15:8], [7:0]) over a valid/ready link.
// Ports:
//   clk, n_rst        : clock, asynchronous active-low reset
//   hash_done         : one-cycle strobe, flag_plus_nonce valid this cycle
//   flag_plus_nonce   : bit 32 = target met, bits 31:0 = nonce
//   clear_overflow    : synchronous clear of the overflow sticky bit
//   tx                : byte-stream master (tx_data / tx_valid / tx_ready)
//   fifo_empty/full   : FIFO occupancy status
//   overflow          : sticky, a winning nonce was dropped
//   found_count       : saturating count of winning nonces seen
//
// state | meaning
// IDLE  | no byte offered; pops the FIFO head into the frame register
// HDR   | offering SYNC_BYTE
// B3    | offering frame[31:24]
// B2    | offering frame[23:16]
// B1    | offering frame[15:8]
// B0    | offering frame[7:0]; acceptance returns to IDLE
module golden_nonce_reporter #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 hash_done,
    input  logic [32:0]          flag_plus_nonce,
    input  logic                 clear_overflow,
    golden_nonce_reporter_if.master tx,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 overflow,
    output logic [CNT_W-1:0]     found_count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, B3, B2, B1, B0} state_t;

    state_t        state, next_state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   frame;
    logic          pop, push_req, push_ok, drop;
    logic          tx_valid_c;
    logic [7:0]    tx_data_c;

    assign push_req   = hash_done & flag_plus_nonce[32];
    // A pop on the same edge frees the slot being written, so a full FIFO
    // still accepts the push.
    assign push_ok    = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);

    assign tx.tx_valid = tx_valid_c;
    assign tx.tx_data  = tx_data_c;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= flag_plus_nonce[31:0];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            found_count <= '0;
            overflow    <= 1'b0;
            frame       <= '0;
            state       <= IDLE;
        end else begin
            if (push_req && (found_count != '1))
                found_count <= found_count + CNT_W'(1);
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
            if (pop)
                frame <= mem[rd_ptr];
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = HDR;
                end
            end
            HDR: begin
                tx_valid_c = 1'b1;
                tx_data_c  = SYNC_BYTE;
                if (tx.tx_ready) next_state = B3;
            end
            B3: begin
                tx_valid_c = 1'b1;
                tx_data_c  = frame[31:24];
                if (tx.tx_ready) next_state = B2;
            end
            B2: begin
                tx_valid_c = 1'b1;
                tx_data_c  = frame[23:16];
                if (tx.tx_ready) next_state = B1;
            end
            B1: begin
                tx_valid_c = 1'b1;
                tx_data_c  = frame[15:8];
                if (tx.tx_ready) next_state = B0;
            end
            B0: begin
                tx_valid_c = 1'b1;
                tx_data_c  = frame[7:0];
                if (tx.tx_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_golden_nonce_reporter.sv
module tb_golden_nonce_reporter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned MAXC  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              hash_done;
    logic [32:0]       flag_plus_nonce;
    logic              clear_overflow;
    logic              fifo_empty, fifo_full, overflow;
    logic [CNT_W-1:0]  found_count;

    golden_nonce_reporter_if txi ();

    golden_nonce_reporter #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .hash_done       (hash_done),
        .flag_plus_nonce (flag_plus_nonce),
        .clear_overflow  (clear_overflow),
        .tx              (txi),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .overflow        (overflow),
        .found_count     (found_count)
    );

    always #5 clk = ~clk;

    // Reference model: nonce queue, bytes still to send for the frame in
    // flight, sticky overflow and found counter.
    logic [31:0] mq[$];
    logic [7:0]  mframe[$];
    logic        m_ovf;
    int unsigned m_found;

    // Bytes the DUT actually handed over, and the bytes expected.
    logic [7:0]  dut_log[$];
    logic [7:0]  exp_log[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    task automatic model_reset();
        mq.delete();
        mframe.delete();
        m_ovf   = 1'b0;
        m_found = 0;
    endtask

    // Applies one clock edge worth of rules to the model using current inputs.
    task automatic model_step();
        logic        pop_now, push_req, was_full, dropped;
        logic [31:0] head;
        pop_now  = (mframe.size() == 0) && (mq.size() > 0);
        push_req = hash_done && flag_plus_nonce[32];
        was_full = (mq.size() == DEPTH);
        dropped  = 1'b0;
        head     = 32'h0;
        if (mframe.size() > 0 && txi.tx_ready) void'(mframe.pop_front());
        if (pop_now) head = mq.pop_front();
        if (push_req) begin
            if (m_found < MAXC) m_found++;
            if (!was_full || pop_now) mq.push_back(flag_plus_nonce[31:0]);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clear_overflow) m_ovf = 1'b0;
        if (pop_now) begin
            mframe.push_back(8'hA5);
            mframe.push_back(head[31:24]);
            mframe.push_back(head[23:16]);
            mframe.push_back(head[15:8]);
            mframe.push_back(head[7:0]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic       e_valid;
        logic [7:0] e_data;
        e_valid = (mframe.size() != 0);
        e_data  = e_valid ? mframe[0] : 8'h00;
        chk("tx_valid",    32'(txi.tx_valid), 32'(e_valid));
        chk("tx_data",     32'(txi.tx_data),  32'(e_data));
        chk("fifo_empty",  32'(fifo_empty),   32'(mq.size() == 0));
        chk("fifo_full",   32'(fifo_full),    32'(mq.size() == DEPTH));
        chk("overflow",    32'(overflow),     32'(m_ovf));
        chk("found_count", 32'(found_count),  m_found);
    endtask

    task automatic step();
        if (n_rst && txi.tx_valid && txi.tx_ready) dut_log.push_back(txi.tx_data);
        if (n_rst) model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic add_frame(input logic [31:0] n);
        exp_log.push_back(8'hA5);
        exp_log.push_back(n[31:24]);
        exp_log.push_back(n[23:16]);
        exp_log.push_back(n[15:8]);
        exp_log.push_back(n[7:0]);
    endtask

    task automatic cmp_log(input string tag);
        int unsigned n;
        chk({tag, "_len"}, 32'(dut_log.size()), 32'(exp_log.size()));
        n = (dut_log.size() < exp_log.size()) ? dut_log.size() : exp_log.size();
        for (int i = 0; i < int'(n); i++) chk(tag, 32'(dut_log[i]), 32'(exp_log[i]));
        dut_log.delete();
        exp_log.delete();
    endtask

    task automatic strobe(input logic flag, input logic [31:0] n);
        hash_done       = 1'b1;
        flag_plus_nonce = {flag, n};
        step();
        hash_done       = 1'b0;
    endtask

    initial begin
        n_rst           = 1'b0;
        hash_done       = 1'b0;
        flag_plus_nonce = '0;
        clear_overflow  = 1'b0;
        txi.tx_ready    = 1'b1;
        model_reset();
        @(negedge clk);
        check_all();
        repeat (2) step();
        n_rst = 1'b1;
        step();

        // Single winning nonce, UART always ready.
        dut_log.delete();
        strobe(1'b1, 32'hDEADBEEF);
        chk("lat_idle", 32'(txi.tx_valid), 32'h0);
        step();
        chk("lat_hdr", 32'(txi.tx_data), 32'hA5);
        repeat (6) step();
        add_frame(32'hDEADBEEF);
        cmp_log("frame_deadbeef");
        chk("found_1", 32'(found_count), 32'd1);

        // Losing result is ignored.
        strobe(1'b0, 32'h12345678);
        repeat (3) step();
        chk("loser_valid", 32'(txi.tx_valid), 32'h0);
        chk("found_still_1", 32'(found_count), 32'd1);

        // Back-pressure in the middle of a frame.
        strobe(1'b1, 32'hCAFEF00D);
        repeat (3) step();
        chk("b2_data", 32'(txi.tx_data), 32'hFE);
        txi.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data", 32'(txi.tx_data), 32'hFE);
            chk("stall_valid", 32'(txi.tx_valid), 32'h1);
        end
        txi.tx_ready = 1'b1;
        repeat (4) step();
        add_frame(32'hCAFEF00D);
        cmp_log("frame_cafef00d");

        // Overflow: six winners with UART stalled.
        txi.tx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) strobe(1'b1, 32'(i));
        step();
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_full", 32'(fifo_full), 32'h1);
        chk("ovf_found", 32'(found_count), 32'd8);
        txi.tx_ready = 1'b1;
        repeat (35) step();
        for (int i = 1; i <= 5; i++) add_frame(32'(i));
        cmp_log("frames_1_5");
        chk("ovf_sticky", 32'(overflow), 32'h1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'h0);

        // Push on the same edge as the IDLE pop while full.
        txi.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) strobe(1'b1, 32'h100 + 32'(i));
        txi.tx_ready = 1'b1;
        repeat (5) step();
        chk("pp_full_before", 32'(fifo_full), 32'h1);
        strobe(1'b1, 32'h105);
        chk("pp_full_after", 32'(fifo_full), 32'h1);
        chk("pp_no_ovf", 32'(overflow), 32'h0);
        repeat (40) step();
        for (int i = 0; i < 6; i++) add_frame(32'h100 + 32'(i));
        cmp_log("frames_pp");

        // Asynchronous reset mid-frame with two nonces queued.
        strobe(1'b1, 32'hAAAA0001);
        strobe(1'b1, 32'hAAAA0002);
        strobe(1'b1, 32'hAAAA0003);
        chk("pre_rst_b3", 32'(txi.tx_data), 32'hAA);
        txi.tx_ready = 1'b0;
        #2 n_rst = 1'b0;
        model_reset();
        #1 check_all();
        chk("rst_found", 32'(found_count), 32'h0);
        step();
        step();
        n_rst = 1'b1;
        txi.tx_ready = 1'b1;
        dut_log.delete();
        exp_log.delete();
        repeat (10) step();
        cmp_log("post_rst");

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            hash_done       = ($urandom_range(0, 2) == 0);
            flag_plus_nonce = {1'($urandom_range(0, 1)), 32'($urandom)};
            clear_overflow  = ($urandom_range(0, 15) == 0);
            txi.tx_ready    = ($urandom_range(0, 9) < 7);
            step();
        end
        hash_done      = 1'b0;
        clear_overflow = 1'b0;

        // Found counter saturation.
        for (int i = 0; i < 300; i++) begin
            hash_done       = 1'b1;
            flag_plus_nonce = {1'b1, 32'($urandom)};
            txi.tx_ready    = 1'($urandom_range(0, 1));
            step();
        end
        hash_done = 1'b0;
        step();
        chk("found_sat", 32'(found_count), MAXC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
